// File: rtl/mips_control_pkg.sv
// Shared constants and types for the MIPS ID-stage main control unit:
// opcode/funct encodings, ALU codes, memory-width codes and the control bundle.
package mips_control_pkg;

  localparam int CANT_BITS_INSTRUCTION           = 32;
  localparam int CANT_BITS_FLAG_BRANCH           = 3;
  localparam int CANT_BITS_ALU_OP                = 2;
  localparam int CANT_BITS_ALU_CONTROL           = 4;
  localparam int CANT_BITS_ESPECIAL              = 6;
  localparam int CANT_BITS_ID_LSB                = 6;
  localparam int CANT_BITS_SELECT_BYTES_MEM_DATA = 2;

  localparam logic [CANT_BITS_INSTRUCTION-1:0] HALT_INSTR = '0;

  localparam logic [CANT_BITS_ESPECIAL-1:0]
    OP_SPECIAL = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04,
    OP_BNE     = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
    OP_ORI     = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F, OP_LB   = 6'h20,
    OP_LH      = 6'h21, OP_LW   = 6'h23, OP_LBU  = 6'h24, OP_LHU  = 6'h25,
    OP_LWU     = 6'h27, OP_SB   = 6'h28, OP_SH   = 6'h29, OP_SW   = 6'h2B;

  localparam logic [CANT_BITS_ID_LSB-1:0]
    FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04,
    FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR   = 6'h08, FN_JALR = 6'h09,
    FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25,
    FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A;

  typedef enum logic [CANT_BITS_ALU_OP-1:0] {
    ALUOP_LDST   = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_IMM    = 2'b11
  } alu_op_e;

  typedef enum logic [CANT_BITS_ALU_CONTROL-1:0] {
    ALU_SLL  = 4'b0000, ALU_SRL  = 4'b0001, ALU_SRA  = 4'b0010, ALU_SLLV = 4'b0011,
    ALU_SRLV = 4'b0100, ALU_SRAV = 4'b0101, ALU_ADD  = 4'b0110, ALU_SUB  = 4'b0111,
    ALU_AND  = 4'b1000, ALU_OR   = 4'b1001, ALU_XOR  = 4'b1010, ALU_NOR  = 4'b1011,
    ALU_SLT  = 4'b1100, ALU_LUI  = 4'b1101
  } alu_ctrl_e;

  typedef enum logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] {
    SEL_NONE = 2'b00,
    SEL_BYTE = 2'b01,
    SEL_HALF = 2'b10,
    SEL_WORD = 2'b11
  } mem_sel_e;

  typedef struct packed {
    logic      reg_dst;
    logic      reg_write;
    logic      alu_src;
    alu_op_e   alu_op;
    alu_ctrl_e alu_ctrl;
    logic      mem_read;
    logic      mem_write;
    logic      mem_to_reg;
    mem_sel_e  mem_sel;
  } ctrl_t;

  function automatic ctrl_t load_ctrl(input mem_sel_e sel);
    ctrl_t c;
    c            = '0;
    c.reg_write  = 1'b1;
    c.alu_src    = 1'b1;
    c.alu_op     = ALUOP_LDST;
    c.alu_ctrl   = ALU_ADD;
    c.mem_read   = 1'b1;
    c.mem_to_reg = 1'b1;
    c.mem_sel    = sel;
    return c;
  endfunction

  function automatic ctrl_t store_ctrl(input mem_sel_e sel);
    ctrl_t c;
    c           = '0;
    c.alu_src   = 1'b1;
    c.alu_op    = ALUOP_LDST;
    c.alu_ctrl  = ALU_ADD;
    c.mem_write = 1'b1;
    c.mem_sel   = sel;
    return c;
  endfunction

  function automatic ctrl_t imm_ctrl(input alu_ctrl_e op);
    ctrl_t c;
    c           = '0;
    c.reg_write = 1'b1;
    c.alu_src   = 1'b1;
    c.alu_op    = ALUOP_IMM;
    c.alu_ctrl  = op;
    return c;
  endfunction

  function automatic ctrl_t rtype_ctrl(input alu_ctrl_e op);
    ctrl_t c;
    c           = '0;
    c.reg_dst   = 1'b1;
    c.reg_write = 1'b1;
    c.alu_op    = ALUOP_RTYPE;
    c.alu_ctrl  = op;
    return c;
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational decode of opcode/funct into the control bundle.
// HALT and anything unrecognised decode to an all-zero, side-effect-free bundle.
module control_decoder
  import mips_control_pkg::*;
(
  input  logic [CANT_BITS_INSTRUCTION-1:0] instruction,
  output ctrl_t                            ctrl
);

  logic [CANT_BITS_ESPECIAL-1:0] opcode;
  logic [CANT_BITS_ID_LSB-1:0]   funct;
  logic                          unused_fields;

  assign opcode        = instruction[31:26];
  assign funct         = instruction[5:0];
  assign unused_fields = ^instruction[25:6];

  always_comb begin
    ctrl = '0;
    // HALT shares its encoding with SLL R0,R0,0, so it must be filtered first
    if (instruction != HALT_INSTR) begin
      case (opcode)
        OP_SPECIAL: begin
          case (funct)
            FN_SLL:  ctrl = rtype_ctrl(ALU_SLL);
            FN_SRL:  ctrl = rtype_ctrl(ALU_SRL);
            FN_SRA:  ctrl = rtype_ctrl(ALU_SRA);
            FN_SLLV: ctrl = rtype_ctrl(ALU_SLLV);
            FN_SRLV: ctrl = rtype_ctrl(ALU_SRLV);
            FN_SRAV: ctrl = rtype_ctrl(ALU_SRAV);
            FN_ADDU: ctrl = rtype_ctrl(ALU_ADD);
            FN_SUBU: ctrl = rtype_ctrl(ALU_SUB);
            FN_AND:  ctrl = rtype_ctrl(ALU_AND);
            FN_OR:   ctrl = rtype_ctrl(ALU_OR);
            FN_XOR:  ctrl = rtype_ctrl(ALU_XOR);
            FN_NOR:  ctrl = rtype_ctrl(ALU_NOR);
            FN_SLT:  ctrl = rtype_ctrl(ALU_SLT);
            FN_JALR: begin
              ctrl.reg_dst   = 1'b1;
              ctrl.reg_write = 1'b1;
              ctrl.alu_ctrl  = ALU_ADD;
            end
            default: ctrl = '0;
          endcase
        end
        OP_LB, OP_LBU:  ctrl = load_ctrl(SEL_BYTE);
        OP_LH, OP_LHU:  ctrl = load_ctrl(SEL_HALF);
        OP_LW, OP_LWU:  ctrl = load_ctrl(SEL_WORD);
        OP_SB:          ctrl = store_ctrl(SEL_BYTE);
        OP_SH:          ctrl = store_ctrl(SEL_HALF);
        OP_SW:          ctrl = store_ctrl(SEL_WORD);
        OP_ADDI:        ctrl = imm_ctrl(ALU_ADD);
        OP_ANDI:        ctrl = imm_ctrl(ALU_AND);
        OP_ORI:         ctrl = imm_ctrl(ALU_OR);
        OP_XORI:        ctrl = imm_ctrl(ALU_XOR);
        OP_LUI:         ctrl = imm_ctrl(ALU_LUI);
        OP_SLTI:        ctrl = imm_ctrl(ALU_SLT);
        OP_BEQ, OP_BNE: begin
          ctrl.alu_op   = ALUOP_BRANCH;
          ctrl.alu_ctrl = ALU_SUB;
        end
        // link register R31 is selected in the datapath, not here
        OP_JAL:         ctrl.reg_write = 1'b1;
        default:        ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/mips_control.sv
// ID-stage main control: registers the decoded control bundle toward ID/EX.
// Outputs freeze while the stage enable is low; reset clears them asynchronously.
module mips_control
  import mips_control_pkg::*;
(
  input  logic                                       i_clock,
  input  logic                                       i_soft_reset,
  input  logic [CANT_BITS_INSTRUCTION-1:0]           i_instruction,
  input  logic                                       i_enable_etapa,
  output logic                                       o_RegDst,
  output logic                                       o_RegWrite,
  output logic                                       o_ALUSrc,
  output logic [CANT_BITS_ALU_OP-1:0]                o_ALUOp,
  output logic [CANT_BITS_ALU_CONTROL-1:0]           o_ALUCtrl,
  output logic                                       o_MemRead,
  output logic                                       o_MemWrite,
  output logic                                       o_MemtoReg,
  output logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] o_select_bytes_mem_datos
);

  ctrl_t ctrl_next;
  ctrl_t ctrl_reg;

  control_decoder u_decoder (
    .instruction (i_instruction),
    .ctrl        (ctrl_next)
  );

  always_ff @(posedge i_clock or posedge i_soft_reset) begin
    if (i_soft_reset)
      ctrl_reg <= '0;
    else if (i_enable_etapa)
      ctrl_reg <= ctrl_next;
  end

  assign o_RegDst                 = ctrl_reg.reg_dst;
  assign o_RegWrite               = ctrl_reg.reg_write;
  assign o_ALUSrc                 = ctrl_reg.alu_src;
  assign o_ALUOp                  = ctrl_reg.alu_op;
  assign o_ALUCtrl                = ctrl_reg.alu_ctrl;
  assign o_MemRead                = ctrl_reg.mem_read;
  assign o_MemWrite               = ctrl_reg.mem_write;
  assign o_MemtoReg               = ctrl_reg.mem_to_reg;
  assign o_select_bytes_mem_datos = ctrl_reg.mem_sel;

endmodule

// File: tb/tb_mips_control.sv
// Directed bench for mips_control: hand-computed control words per instruction,
// including enable hold, asynchronous reset and HALT/undefined decodes.
module tb_mips_control;

  logic        clock;
  logic        reset;
  logic [31:0] instruction;
  logic        enable;

  logic        reg_dst, reg_write, alu_src, mem_read, mem_write, mem_to_reg;
  logic [1:0]  alu_op, sel;
  logic [3:0]  alu_ctrl;
  logic [13:0] observed;

  int compared   = 0;
  int mismatched = 0;

  mips_control dut (
    .i_clock                  (clock),
    .i_soft_reset             (reset),
    .i_instruction            (instruction),
    .i_enable_etapa           (enable),
    .o_RegDst                 (reg_dst),
    .o_RegWrite               (reg_write),
    .o_ALUSrc                 (alu_src),
    .o_ALUOp                  (alu_op),
    .o_ALUCtrl                (alu_ctrl),
    .o_MemRead                (mem_read),
    .o_MemWrite               (mem_write),
    .o_MemtoReg               (mem_to_reg),
    .o_select_bytes_mem_datos (sel)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign observed = {reg_dst, reg_write, alu_src, alu_op, alu_ctrl,
                     mem_read, mem_write, mem_to_reg, sel};

  // Field order: RegDst RegWrite ALUSrc ALUOp ALUCtrl MemRead MemWrite MemtoReg sel
  function automatic logic [13:0] exp_word(input logic rd, input logic rw, input logic src,
                                           input logic [1:0] op, input logic [3:0] ctl,
                                           input logic mr, input logic mw, input logic m2r,
                                           input logic [1:0] s);
    return {rd, rw, src, op, ctl, mr, mw, m2r, s};
  endfunction

  task automatic checkOutput(input string tag, input logic [13:0] actual, input logic [13:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic en);
    @(negedge clock);
    instruction = instr;
    enable      = en;
    @(posedge clock);
    #1;
  endtask

  localparam logic [13:0] ZERO = 14'b0;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    enable      = 1'b1;
    instruction = 32'h000110C0;
    #3;
    checkOutput("reset_async", observed, ZERO);
    @(posedge clock); #1;
    @(posedge clock); #1;
    checkOutput("reset_held", observed, ZERO);

    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("sll", observed, exp_word(1,1,0,2'b10,4'b0000,0,0,0,2'b00));

    applyStimulus(32'h00221804, 1'b1);
    checkOutput("sllv", observed, exp_word(1,1,0,2'b10,4'b0011,0,0,0,2'b00));
    applyStimulus(32'h00221821, 1'b0);
    checkOutput("hold_en0", observed, exp_word(1,1,0,2'b10,4'b0011,0,0,0,2'b00));
    applyStimulus(32'h00221821, 1'b1);
    checkOutput("addu", observed, exp_word(1,1,0,2'b10,4'b0110,0,0,0,2'b00));

    applyStimulus(32'h02800008, 1'b1);
    checkOutput("jr", observed, ZERO);
    applyStimulus(32'h12830009, 1'b1);
    checkOutput("beq", observed, exp_word(0,0,0,2'b01,4'b0111,0,0,0,2'b00));
    applyStimulus(32'h16830009, 1'b1);
    checkOutput("bne", observed, exp_word(0,0,0,2'b01,4'b0111,0,0,0,2'b00));
    applyStimulus(32'h08000007, 1'b1);
    checkOutput("j", observed, ZERO);
    applyStimulus(32'h0C000007, 1'b1);
    checkOutput("jal", observed, exp_word(0,1,0,2'b00,4'b0000,0,0,0,2'b00));
    applyStimulus(32'h02800009, 1'b1);
    checkOutput("jalr", observed, exp_word(1,1,0,2'b00,4'b0110,0,0,0,2'b00));

    applyStimulus(32'h82A10008, 1'b1);
    checkOutput("lb", observed, exp_word(0,1,1,2'b00,4'b0110,1,0,1,2'b01));
    applyStimulus(32'h94220004, 1'b1);
    checkOutput("lhu", observed, exp_word(0,1,1,2'b00,4'b0110,1,0,1,2'b10));
    applyStimulus(32'h8C220004, 1'b1);
    checkOutput("lw", observed, exp_word(0,1,1,2'b00,4'b0110,1,0,1,2'b11));
    applyStimulus(32'hA2A10008, 1'b1);
    checkOutput("sb", observed, exp_word(0,0,1,2'b00,4'b0110,0,1,0,2'b01));
    applyStimulus(32'hA4220004, 1'b1);
    checkOutput("sh", observed, exp_word(0,0,1,2'b00,4'b0110,0,1,0,2'b10));
    applyStimulus(32'hAC220004, 1'b1);
    checkOutput("sw", observed, exp_word(0,0,1,2'b00,4'b0110,0,1,0,2'b11));

    applyStimulus(32'h20220005, 1'b1);
    checkOutput("addi", observed, exp_word(0,1,1,2'b11,4'b0110,0,0,0,2'b00));
    applyStimulus(32'h34220005, 1'b1);
    checkOutput("ori", observed, exp_word(0,1,1,2'b11,4'b1001,0,0,0,2'b00));
    applyStimulus(32'h3C010005, 1'b1);
    checkOutput("lui", observed, exp_word(0,1,1,2'b11,4'b1101,0,0,0,2'b00));
    applyStimulus(32'h28220005, 1'b1);
    checkOutput("slti", observed, exp_word(0,1,1,2'b11,4'b1100,0,0,0,2'b00));

    applyStimulus(32'h00221823, 1'b1);
    checkOutput("subu", observed, exp_word(1,1,0,2'b10,4'b0111,0,0,0,2'b00));
    applyStimulus(32'h00221827, 1'b1);
    checkOutput("nor", observed, exp_word(1,1,0,2'b10,4'b1011,0,0,0,2'b00));
    applyStimulus(32'h00221007, 1'b1);
    checkOutput("srav", observed, exp_word(1,1,0,2'b10,4'b0101,0,0,0,2'b00));
    applyStimulus(32'h03E1802A, 1'b1);
    checkOutput("slt", observed, exp_word(1,1,0,2'b10,4'b1100,0,0,0,2'b00));
    applyStimulus(32'h00000000, 1'b1);
    checkOutput("halt", observed, ZERO);
    applyStimulus(32'h03E1802A, 1'b1);
    applyStimulus(32'h00221801, 1'b1);
    checkOutput("undef_funct", observed, ZERO);
    applyStimulus(32'h03E1802A, 1'b1);
    applyStimulus(32'hFC000000, 1'b1);
    checkOutput("undef_opcode", observed, ZERO);

    applyStimulus(32'h03E1802A, 1'b1);
    checkOutput("slt_reload", observed, exp_word(1,1,0,2'b10,4'b1100,0,0,0,2'b00));
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("reset_midcycle", observed, ZERO);
    @(posedge clock); #1;
    checkOutput("reset_over_en", observed, ZERO);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("post_reset_reload", observed, exp_word(1,1,0,2'b10,4'b1100,0,0,0,2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
